// File: rtl/branch_sequencer.sv
// Next-PC controller for the KGP-RISC core: owns the program counter and the
// return-address stack, and sequences fetch with one bubble after each redirect.
module branch_sequencer #(
   parameter int              PC_W      = 10,
   parameter int              RAS_DEPTH = 8,
   parameter logic [PC_W-1:0] RESET_PC  = {PC_W{1'b0}}
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           instr_valid,
   input  logic                           stall,
   input  logic [1:0]                     opcode,
   input  logic [3:0]                     fcode,
   input  logic [15:0]                    label,
   input  logic                           carry_flag,
   input  logic                           zero_flag,
   input  logic                           overflow_flag,
   input  logic                           sign_flag,
   output logic [PC_W-1:0]                pc,
   output logic                           fetch_en,
   output logic                           flush,
   output logic [PC_W-1:0]                ra_top,
   output logic [$clog2(RAS_DEPTH):0]     ras_count,
   output logic                           fault,
   output logic [1:0]                     fault_code
);

   localparam int IDX_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_TWO  = {{(CNT_W-2){1'b0}}, 2'b10};

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RUN    = 2'b01,
      S_BUBBLE = 2'b10,
      S_FAULT  = 2'b11
   } state_e;

   state_e              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PC_W-1:0]     top_q, top_d;
   logic [1:0]          fcode_q, fcode_d;
   logic                fetch_en_q, fetch_en_d;
   logic                flush_q, flush_d;
   logic                fault_q, fault_d;
   logic [PC_W-1:0]     stack_q [RAS_DEPTH];

   logic                push_s;
   logic                cond_s;
   logic [PC_W-1:0]     pc_inc_s;
   logic [PC_W-1:0]     target_s;
   logic [CNT_W-1:0]    below_s;

   assign pc_inc_s = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
   assign target_s = label[PC_W-1:0];
   assign below_s  = cnt_q - CNT_TWO;

   // Condition evaluation for the flag-qualified branch codes
   always_comb begin
      cond_s = 1'b0;
      case (fcode)
         4'b0100: cond_s = zero_flag;
         4'b0101: cond_s = ~zero_flag;
         4'b0110: cond_s = sign_flag;
         4'b0111: cond_s = ~sign_flag;
         4'b1001: cond_s = carry_flag;
         4'b1010: cond_s = ~carry_flag;
         4'b1011: cond_s = overflow_flag;
         4'b1100: cond_s = ~overflow_flag;
         default: cond_s = 1'b0;
      endcase
   end

   // Next-state, next-PC and stack bookkeeping
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      top_d   = top_q;
      fcode_d = fcode_q;
      push_s  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!stall && start) begin
               state_d = S_RUN;
               pc_d    = RESET_PC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (!stall && instr_valid) begin
               if (opcode != 2'b11) begin
                  pc_d = pc_inc_s;
               end else begin
                  case (fcode)
                     4'b0000, 4'b0011: begin
                        pc_d    = target_s;
                        state_d = S_BUBBLE;
                     end
                     4'b0001: begin
                        if (cnt_q == FULL_CNT) begin
                           state_d = S_FAULT;
                           fcode_d = 2'b01;
                        end else begin
                           push_s  = 1'b1;
                           cnt_d   = cnt_q + CNT_ONE;
                           top_d   = pc_inc_s;
                           pc_d    = target_s;
                           state_d = S_BUBBLE;
                        end
                     end
                     4'b0010: begin
                        if (cnt_q == {CNT_W{1'b0}}) begin
                           state_d = S_FAULT;
                           fcode_d = 2'b10;
                        end else begin
                           cnt_d   = cnt_q - CNT_ONE;
                           top_d   = (cnt_q >= CNT_TWO) ? stack_q[below_s[IDX_W-1:0]]
                                                        : {PC_W{1'b0}};
                           pc_d    = top_q;
                           state_d = S_BUBBLE;
                        end
                     end
                     4'b0100, 4'b0101, 4'b0110, 4'b0111,
                     4'b1001, 4'b1010, 4'b1011, 4'b1100: begin
                        if (cond_s) begin
                           pc_d    = target_s;
                           state_d = S_BUBBLE;
                        end else begin
                           pc_d = pc_inc_s;
                        end
                     end
                     default: begin
                        state_d = S_FAULT;
                        fcode_d = 2'b11;
                     end
                  endcase
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_BUBBLE: begin
            if (!stall) begin
               state_d = S_RUN;
            end else begin
               state_d = S_BUBBLE;
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output flags follow the state being entered so they are registered
   always_comb begin
      fetch_en_d = (state_d == S_RUN) || (state_d == S_BUBBLE);
      flush_d    = (state_d == S_BUBBLE);
      fault_d    = (state_d == S_FAULT);
   end

   // Control and status registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         cnt_q      <= {CNT_W{1'b0}};
         top_q      <= {PC_W{1'b0}};
         fcode_q    <= 2'b00;
         fetch_en_q <= 1'b0;
         flush_q    <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         cnt_q      <= cnt_d;
         top_q      <= top_d;
         fcode_q    <= fcode_d;
         fetch_en_q <= fetch_en_d;
         flush_q    <= flush_d;
         fault_q    <= fault_d;
      end
   end

   // Stack storage; contents are meaningful only below cnt_q, so no reset
   always_ff @(posedge clk) begin
      if (push_s) begin
         stack_q[cnt_q[IDX_W-1:0]] <= pc_inc_s;
      end
   end

   assign pc         = pc_q;
   assign fetch_en   = fetch_en_q;
   assign flush      = flush_q;
   assign ra_top     = top_q;
   assign ras_count  = cnt_q;
   assign fault      = fault_q;
   assign fault_code = fcode_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed self-checking bench for branch_sequencer (default parameters).
module tb_branch_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        instr_valid = 1'b0;
   logic        stall = 1'b0;
   logic [1:0]  opcode = 2'b00;
   logic [3:0]  fcode = 4'b0000;
   logic [15:0] label = 16'h0000;
   logic        carry_flag = 1'b0;
   logic        zero_flag = 1'b0;
   logic        overflow_flag = 1'b0;
   logic        sign_flag = 1'b0;
   logic [9:0]  pc;
   logic        fetch_en;
   logic        flush;
   logic [9:0]  ra_top;
   logic [3:0]  ras_count;
   logic        fault;
   logic [1:0]  fault_code;

   int n_checks = 0;
   int n_fail   = 0;

   branch_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .instr_valid(instr_valid), .stall(stall),
      .opcode(opcode), .fcode(fcode), .label(label),
      .carry_flag(carry_flag), .zero_flag(zero_flag),
      .overflow_flag(overflow_flag), .sign_flag(sign_flag),
      .pc(pc), .fetch_en(fetch_en), .flush(flush), .ra_top(ra_top),
      .ras_count(ras_count), .fault(fault), .fault_code(fault_code)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      instr_valid = 1'b0; opcode = 2'b00; fcode = 4'b0000; label = 16'h0000;
      start = 1'b0; stall = 1'b0;
      zero_flag = 1'b0; sign_flag = 1'b0; carry_flag = 1'b0; overflow_flag = 1'b0;
   endtask

   task automatic restart();
      idle_inputs();
      rst = 1'b1; tick(); rst = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic branch(input logic [3:0] f, input logic [15:0] lab);
      instr_valid = 1'b1; opcode = 2'b11; fcode = f; label = lab;
   endtask

   task automatic jump(input logic [15:0] lab);
      branch(4'b0000, lab); tick();
      idle_inputs(); tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1; #2;
      n_checks++;
      if ({pc, fetch_en, flush, ra_top, ras_count, fault, fault_code} !== 29'd0) begin
         $display("FAIL reset_outputs: got pc=%h fe=%b fl=%b top=%h cnt=%0d f=%b fc=%b, want all 0",
                  pc, fetch_en, flush, ra_top, ras_count, fault, fault_code);
         n_fail++;
      end
      tick(); rst = 1'b0; tick();
      n_checks++;
      if (fetch_en !== 1'b0) begin
         $display("FAIL idle_fetch_en: got %b want 0", fetch_en); n_fail++;
      end
   endtask

   task automatic test_sequential();
      restart();
      n_checks++;
      if (pc !== 10'd0 || fetch_en !== 1'b1) begin
         $display("FAIL start: got pc=%h fe=%b want pc=000 fe=1", pc, fetch_en); n_fail++;
      end
      instr_valid = 1'b1; opcode = 2'b00;
      for (int i = 1; i <= 5; i++) begin
         tick();
         n_checks++;
         if (pc !== 10'(i) || flush !== 1'b0) begin
            $display("FAIL seq_pc[%0d]: got pc=%h fl=%b want pc=%h fl=0", i, pc, flush, 10'(i));
            n_fail++;
         end
      end
      instr_valid = 1'b0; tick();
      n_checks++;
      if (pc !== 10'd5) begin
         $display("FAIL invalid_hold: got pc=%h want 005", pc); n_fail++;
      end
   endtask

   task automatic test_cond_branch();
      for (int z = 1; z >= 0; z--) begin
         restart();
         instr_valid = 1'b1; opcode = 2'b00;
         tick(); tick(); tick();
         branch(4'b0100, 16'h0040); zero_flag = (z == 1);
         tick();
         n_checks++;
         if (z == 1 && (pc !== 10'h040 || flush !== 1'b1)) begin
            $display("FAIL bz_taken: got pc=%h fl=%b want pc=040 fl=1", pc, flush); n_fail++;
         end else if (z == 0 && (pc !== 10'h004 || flush !== 1'b0)) begin
            $display("FAIL bz_not_taken: got pc=%h fl=%b want pc=004 fl=0", pc, flush); n_fail++;
         end
         if (z == 1) begin
            instr_valid = 1'b1; opcode = 2'b00; zero_flag = 1'b0;
            tick();
            n_checks++;
            if (pc !== 10'h040 || flush !== 1'b0) begin
               $display("FAIL bubble_ignore: got pc=%h fl=%b want pc=040 fl=0", pc, flush); n_fail++;
            end
         end
      end
      restart();
      branch(4'b0111, 16'h0123); sign_flag = 1'b0;
      tick();
      n_checks++;
      if (pc !== 10'h123 || flush !== 1'b1) begin
         $display("FAIL bns_taken: got pc=%h fl=%b want pc=123 fl=1", pc, flush); n_fail++;
      end
      idle_inputs(); tick();
      branch(4'b1011, 16'h0200); overflow_flag = 1'b0;
      tick();
      n_checks++;
      if (pc !== 10'h124 || flush !== 1'b0) begin
         $display("FAIL bv_not_taken: got pc=%h fl=%b want pc=124 fl=0", pc, flush); n_fail++;
      end
   endtask

   task automatic test_call_ret();
      restart();
      jump(16'h0010);
      branch(4'b0001, 16'h0100); tick();
      n_checks++;
      if (pc !== 10'h100 || ra_top !== 10'h011 || ras_count !== 4'd1 || flush !== 1'b1) begin
         $display("FAIL call: got pc=%h top=%h cnt=%0d fl=%b want pc=100 top=011 cnt=1 fl=1",
                  pc, ra_top, ras_count, flush);
         n_fail++;
      end
      idle_inputs(); tick();
      jump(16'h0105);
      branch(4'b0010, 16'h0000); tick();
      n_checks++;
      if (pc !== 10'h011 || ras_count !== 4'd0 || ra_top !== 10'h000 || flush !== 1'b1) begin
         $display("FAIL ret: got pc=%h cnt=%0d top=%h fl=%b want pc=011 cnt=0 top=000 fl=1",
                  pc, ras_count, ra_top, flush);
         n_fail++;
      end
   endtask

   task automatic test_overflow_underflow();
      restart();
      for (int i = 0; i < 8; i++) begin
         branch(4'b0001, 16'h0020 + 16'(i)); tick();
         idle_inputs(); tick();
      end
      n_checks++;
      if (ras_count !== 4'd8 || ra_top !== 10'h027 || pc !== 10'h027) begin
         $display("FAIL stack_full: got cnt=%0d top=%h pc=%h want cnt=8 top=027 pc=027",
                  ras_count, ra_top, pc);
         n_fail++;
      end
      branch(4'b0001, 16'h0300); tick();
      n_checks++;
      if (fault !== 1'b1 || fault_code !== 2'b01 || pc !== 10'h027 || fetch_en !== 1'b0 ||
          ras_count !== 4'd8) begin
         $display("FAIL overflow: got f=%b fc=%b pc=%h fe=%b cnt=%0d want f=1 fc=01 pc=027 fe=0 cnt=8",
                  fault, fault_code, pc, fetch_en, ras_count);
         n_fail++;
      end
      idle_inputs(); start = 1'b1; tick(); start = 1'b0; tick();
      n_checks++;
      if (fault !== 1'b1 || fault_code !== 2'b01 || fetch_en !== 1'b0 || pc !== 10'h027) begin
         $display("FAIL fault_sticky: got f=%b fc=%b fe=%b pc=%h want f=1 fc=01 fe=0 pc=027",
                  fault, fault_code, fetch_en, pc);
         n_fail++;
      end
      restart();
      branch(4'b0010, 16'h0055); tick();
      n_checks++;
      if (fault !== 1'b1 || fault_code !== 2'b10 || pc !== 10'h000) begin
         $display("FAIL underflow: got f=%b fc=%b pc=%h want f=1 fc=10 pc=000",
                  fault, fault_code, pc);
         n_fail++;
      end
   endtask

   task automatic test_wrap_and_stall();
      restart();
      jump(16'hFFFF);
      n_checks++;
      if (pc !== 10'h3FF) begin
         $display("FAIL label_trunc: got pc=%h want 3ff", pc); n_fail++;
      end
      instr_valid = 1'b1; opcode = 2'b10; tick();
      n_checks++;
      if (pc !== 10'h000) begin
         $display("FAIL pc_wrap: got pc=%h want 000", pc); n_fail++;
      end
      idle_inputs();
      jump(16'h0050);
      branch(4'b0001, 16'h0200); stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (pc !== 10'h050 || ras_count !== 4'd0 || flush !== 1'b0 || fetch_en !== 1'b1) begin
            $display("FAIL stall_hold[%0d]: got pc=%h cnt=%0d fl=%b fe=%b want pc=050 cnt=0 fl=0 fe=1",
                     i, pc, ras_count, flush, fetch_en);
            n_fail++;
         end
      end
      stall = 1'b0; tick();
      n_checks++;
      if (pc !== 10'h200 || ras_count !== 4'd1 || ra_top !== 10'h051 || flush !== 1'b1) begin
         $display("FAIL stall_release: got pc=%h cnt=%0d top=%h fl=%b want pc=200 cnt=1 top=051 fl=1",
                  pc, ras_count, ra_top, flush);
         n_fail++;
      end
      idle_inputs(); stall = 1'b1; tick(); tick();
      n_checks++;
      if (flush !== 1'b1 || pc !== 10'h200) begin
         $display("FAIL bubble_stall: got fl=%b pc=%h want fl=1 pc=200", flush, pc); n_fail++;
      end
      stall = 1'b0; tick();
      n_checks++;
      if (flush !== 1'b0 || fetch_en !== 1'b1) begin
         $display("FAIL bubble_exit: got fl=%b fe=%b want fl=0 fe=1", flush, fetch_en); n_fail++;
      end
   endtask

   task automatic test_async_reset();
      restart();
      branch(4'b0001, 16'h0030); tick();
      idle_inputs();
      #2 rst = 1'b1; #1;
      n_checks++;
      if ({pc, fetch_en, flush, ra_top, ras_count, fault, fault_code} !== 29'd0) begin
         $display("FAIL rst_in_bubble: got pc=%h fe=%b fl=%b top=%h cnt=%0d, want all 0",
                  pc, fetch_en, flush, ra_top, ras_count);
         n_fail++;
      end
      #1 rst = 1'b0;
      restart();
      branch(4'b0001, 16'h0060); tick();
      idle_inputs(); tick();
      branch(4'b1110, 16'h0000); tick();
      n_checks++;
      if (fault !== 1'b1 || fault_code !== 2'b11 || pc !== 10'h060 || ras_count !== 4'd1) begin
         $display("FAIL illegal_fcode: got f=%b fc=%b pc=%h cnt=%0d want f=1 fc=11 pc=060 cnt=1",
                  fault, fault_code, pc, ras_count);
         n_fail++;
      end
      idle_inputs();
      #2 rst = 1'b1; #1;
      n_checks++;
      if ({pc, fetch_en, flush, ra_top, ras_count, fault, fault_code} !== 29'd0) begin
         $display("FAIL rst_in_fault: got pc=%h top=%h cnt=%0d f=%b fc=%b, want all 0",
                  pc, ra_top, ras_count, fault, fault_code);
         n_fail++;
      end
      #1 rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_cond_branch();
      test_call_ret();
      test_overflow_underflow();
      test_wrap_and_stall();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
